// File: rtl/truthtable_pkg.sv
// Shared types and constants for the 3-input truth-table function block.
package truthtable_pkg;

  localparam logic [7:0] TT_F3_MASK = 8'hAC;

  typedef logic [2:0] tt_idx_t;

  function automatic logic [7:0] tt_onehot(input tt_idx_t idx);
    tt_onehot = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/truthtable_lut.sv
// Combinational lookup: returns the mask bit selected by a 3-bit index.
module truthtable_lut
  import truthtable_pkg::*;
#(
  parameter logic [7:0] MASK = TT_F3_MASK
) (
  input  tt_idx_t idx_i,
  output logic    f_o
);

  // Index the table directly; every index value is a valid mask bit.
  always_comb begin
    f_o = MASK[idx_i];
  end

endmodule

// File: rtl/truthtable_f3.sv
// Truth-table function f = TT_MASK[{x3,x2,x1}] with a registered copy f_q.
// Optional index coverage tracking is enabled with the TRUTHTABLE_COV_EN macro.
module truthtable_f3
  import truthtable_pkg::*;
#(
  parameter logic [7:0] TT_MASK = TT_F3_MASK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x3,
  input  logic       x2,
  input  logic       x1,
  output logic       f,
  output logic       f_q
`ifdef TRUTHTABLE_COV_EN
  ,
  output logic [7:0] cov_seen,
  output logic       cov_all
`endif
);

  tt_idx_t idx_s;
  logic    f_s;
  logic    f_q_d;

  assign idx_s = {x3, x2, x1};

  truthtable_lut #(
    .MASK (TT_MASK)
  ) u_lut (
    .idx_i (idx_s),
    .f_o   (f_s)
  );

  // f stays purely combinational so it is valid during reset.
  assign f = f_s;

  // Next value of the output register.
  always_comb begin
    f_q_d = f_s;
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f_q_d;
    end
  end

`ifdef TRUTHTABLE_COV_EN
  logic [7:0] cov_seen_q;
  logic [7:0] cov_seen_d;

  // Sticky record of every index sampled on a rising edge.
  always_comb begin
    cov_seen_d = cov_seen_q | tt_onehot(idx_s);
  end

  // Coverage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_seen_q <= 8'h00;
    end else begin
      cov_seen_q <= cov_seen_d;
    end
  end

  assign cov_seen = cov_seen_q;
  assign cov_all  = &cov_seen_q;
`endif

endmodule

// File: tb/tb_truthtable_f3.sv
// Self-checking bench for truthtable_f3: table sweep, wrap, reset, random and
// (with TRUTHTABLE_COV_EN) coverage sequences; f_q is checked via a scoreboard queue.
module tb_truthtable_f3;

  logic       clk;
  logic       reset;
  logic [2:0] idx;
  logic       f;
  logic       f_q;
`ifdef TRUTHTABLE_COV_EN
  logic [7:0] cov_seen;
  logic       cov_all;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit sb_en    = 1'b0;
  logic sb_q[$];

  typedef struct {
    logic [2:0] idx;
    logic       f_exp;
  } vec_t;
  vec_t tbl[8];

  truthtable_f3 dut (
    .clk      (clk),
    .reset    (reset),
    .x3       (idx[2]),
    .x2       (idx[1]),
    .x1       (idx[0]),
    .f        (f),
    .f_q      (f_q)
`ifdef TRUTHTABLE_COV_EN
    ,
    .cov_seen (cov_seen),
    .cov_all  (cov_all)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_f(input logic [2:0] i);
    model_f = (~i[2] & i[1]) | (i[2] & i[0]);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected f_q pushed at each rising edge, popped just after it.
  always @(posedge clk) begin
    logic e;
    sb_q.push_back(reset ? 1'b0 : model_f(idx));
    #1;
    e = sb_q.pop_front();
    if (sb_en) check("f_q_sb", {7'h00, f_q}, {7'h00, e});
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3'd0, 1'b0};
    tbl[1] = '{3'd1, 1'b0};
    tbl[2] = '{3'd2, 1'b1};
    tbl[3] = '{3'd3, 1'b1};
    tbl[4] = '{3'd4, 1'b0};
    tbl[5] = '{3'd5, 1'b1};
    tbl[6] = '{3'd6, 1'b0};
    tbl[7] = '{3'd7, 1'b1};

    reset = 1'b1;
    idx   = 3'd0;
    @(posedge clk);
    #1;
    check("f_q_reset", {7'h00, f_q}, 8'h00);
    check("f_in_reset", {7'h00, f}, 8'h00);
    sb_en = 1'b1;
    reset = 1'b0;

    // Half-cycle sweep of the table
    for (int i = 0; i < 8; i++) begin
      @(clk);
      #1;
      idx = tbl[i].idx;
      #1;
      check("sweep_f", {7'h00, f}, {7'h00, tbl[i].f_exp});
    end

    // Wrap from 7 through 0, checking at both edges
    @(negedge clk);
    #1;
    idx = 3'd7;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check("wrap_f_rise", {7'h00, f}, {7'h00, tbl[idx].f_exp});
      @(negedge clk);
      #1;
      check("wrap_f_fall", {7'h00, f}, {7'h00, tbl[idx].f_exp});
      idx = idx + 3'd1;
    end

    // Synchronous reset held for two edges with index 010
    reset = 1'b1;
    idx   = 3'b010;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("rst_f_q", {7'h00, f_q}, 8'h00);
      check("rst_f", {7'h00, f}, 8'h01);
    end
    reset = 1'b0;
    #1;
    check("rel_f", {7'h00, f}, 8'h01);
    @(posedge clk);
    #1;
    check("rel_f_q", {7'h00, f_q}, 8'h01);

    // Random inputs
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      idx = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      check("rand_f", {7'h00, f}, {7'h00, model_f(idx)});
    end

`ifdef TRUTHTABLE_COV_EN
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("cov_reset", cov_seen, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      idx = 3'(i);
      @(posedge clk);
      #1;
    end
    check("cov_0to6", cov_seen, 8'h7F);
    check("cov_all_0", {7'h00, cov_all}, 8'h00);
    idx = 3'd7;
    @(posedge clk);
    #1;
    check("cov_full", cov_seen, 8'hFF);
    check("cov_all_1", {7'h00, cov_all}, 8'h01);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("cov_clear", cov_seen, 8'h00);
    reset = 1'b0;
`endif

    @(posedge clk);
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
